// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: handshake and data bundle for imm_gen_stage.
//   in side  : in_valid/in_ready, instruction, pc, ImmSel
//   out side : out_valid/out_ready, Imm_out, target_out, illegal_out
//   modport slave  : the stage itself
//   modport master : the upstream/downstream agent driving the stage
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic [2:0]      ImmSel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Imm_out;
    logic [XLEN-1:0] target_out;
    logic            illegal_out;

    modport slave (
        input  in_valid, instruction, pc, ImmSel, out_ready,
        output in_ready, out_valid, Imm_out, target_out, illegal_out
    );

    modport master (
        output in_valid, instruction, pc, ImmSel, out_ready,
        input  in_ready, out_valid, Imm_out, target_out, illegal_out
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: pipelined RV32I immediate generator with PC-relative target.
// Decode and pc+imm are combinational on the input side; results land in a
// 2-entry skid buffer (main + skid) so in_ready depends on registered state only.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   flush  - synchronous discard of all buffered entries (beats the handshakes)
//   bus    - imm_gen_stage_if.slave (input handshake + instruction/pc/ImmSel,
//            output handshake + Imm_out/target_out/illegal_out)
//
// Build option: IMM_AUTODECODE_EN - when defined, ImmSel is ignored and the
// format is derived from the opcode in instruction[6:0].
//
// state | meaning
// EMPTY | no entry held, outputs not valid
// ONE   | main register holds the head entry
// TWO   | main and skid both full, input stalled
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    imm_gen_stage_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] imm;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    fmt_e   fmt;
    logic [31:0] imm32;
    logic   accept;
    logic   drain;

    always_comb begin
        fmt = FMT_BAD;
`ifdef IMM_AUTODECODE_EN
        case (bus.instruction[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b1100011:                                     fmt = FMT_B;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            default:                                        fmt = FMT_BAD;
        endcase
`else
        case (bus.ImmSel)
            3'b000:  fmt = FMT_I;
            3'b001:  fmt = FMT_S;
            3'b010:  fmt = FMT_B;
            3'b011:  fmt = FMT_U;
            3'b100:  fmt = FMT_J;
            default: fmt = FMT_BAD;
        endcase
`endif
    end

`ifdef IMM_AUTODECODE_EN
    logic unused_sel;
    assign unused_sel = ^bus.ImmSel;
`else
    logic unused_opcode;
    assign unused_opcode = ^bus.instruction[6:0];
`endif

    // All formats sign-extend from instruction[31], so build the RV32 value
    // first and widen it with a signed cast for RV64.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
            FMT_S:   imm32 = {{20{bus.instruction[31]}}, bus.instruction[31:25],
                              bus.instruction[11:7]};
            FMT_B:   imm32 = {{19{bus.instruction[31]}}, bus.instruction[31],
                              bus.instruction[7], bus.instruction[30:25],
                              bus.instruction[11:8], 1'b0};
            FMT_U:   imm32 = {bus.instruction[31:12], 12'b0};
            FMT_J:   imm32 = {{11{bus.instruction[31]}}, bus.instruction[31],
                              bus.instruction[19:12], bus.instruction[20],
                              bus.instruction[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        new_entry.imm     = XLEN'($signed(imm32));
        new_entry.target  = bus.pc + new_entry.imm;
        new_entry.illegal = (fmt == FMT_BAD);
    end

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = new_entry;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = new_entry;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = new_entry;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready    = (state_q != TWO);
    assign bus.out_valid   = (state_q != EMPTY);
    assign bus.Imm_out     = main_q.imm;
    assign bus.target_out  = main_q.target;
    assign bus.illegal_out = main_q.illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush32 = 1'b0;
    logic flush64 = 1'b0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32)) b32();
    imm_gen_stage_if #(.XLEN(64)) b64();

    imm_gen_stage #(.XLEN(32)) u_dut32 (.clk(clk), .reset(reset), .flush(flush32), .bus(b32));
    imm_gen_stage #(.XLEN(64)) u_dut64 (.clk(clk), .reset(reset), .flush(flush64), .bus(b64));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        bit          ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    logic [31:0] drained[$];
    bit acc32, drn32, acc64, drn64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Format index: 0=I 1=S 2=B 3=U 4=J 5=invalid
    function automatic int fmt_of(input logic [31:0] ins, input logic [2:0] sel);
`ifdef IMM_AUTODECODE_EN
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 0;
            7'h23:                      return 1;
            7'h63:                      return 2;
            7'h37, 7'h17:               return 3;
            7'h6F:                      return 4;
            default:                    return 5;
        endcase
`else
        return (sel <= 3'd4) ? int'(sel) : 5;
`endif
    endfunction

    // Field value as an unsigned number, scaled, then two's-complement
    // interpreted over the format's total width.
    function automatic longint model_imm(input logic [31:0] ins, input int f);
        longint v;
        int     w;
        case (f)
            0: begin v = longint'(ins[31:20]); w = 12; end
            1: begin v = longint'({ins[31:25], ins[11:7]}); w = 12; end
            2: begin v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2; w = 13; end
            3: begin v = longint'(ins[31:12]) * 4096; w = 32; end
            4: begin v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2; w = 21; end
            default: return 0;
        endcase
        if (ins[31]) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] sel,
                                   input logic [63:0] p, input int xlen);
        exp_t   e;
        int     f = fmt_of(ins, sel);
        longint v = model_imm(ins, f);
        e.ill = (f == 5);
        e.imm = 64'(v);
        e.tgt = p + e.imm;
        if (xlen == 32) begin
            e.imm = {32'h0, e.imm[31:0]};
            e.tgt = {32'h0, e.tgt[31:0]};
        end
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset || flush32) begin
            q32.delete();
        end else begin
            acc32 = b32.in_valid && (q32.size() < 2);
            drn32 = (q32.size() > 0) && b32.out_ready;
            if (drn32) void'(q32.pop_front());
            if (acc32) q32.push_back(model(b32.instruction, b32.ImmSel, {32'h0, b32.pc}, 32));
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset || flush64) begin
            q64.delete();
        end else begin
            acc64 = b64.in_valid && (q64.size() < 2);
            drn64 = (q64.size() > 0) && b64.out_ready;
            if (drn64) void'(q64.pop_front());
            if (acc64) q64.push_back(model(b64.instruction, b64.ImmSel, b64.pc, 64));
        end
    end

    always @(posedge clk) begin
        if (!reset && b32.out_valid && b32.out_ready) drained.push_back(b32.Imm_out);
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready32", 64'(b32.in_ready), 64'(q32.size() < 2));
            check("out_valid32", 64'(b32.out_valid), 64'(q32.size() > 0));
            if (q32.size() > 0) begin
                check("imm32", {32'h0, b32.Imm_out}, q32[0].imm);
                check("target32", {32'h0, b32.target_out}, q32[0].tgt);
                check("illegal32", 64'(b32.illegal_out), 64'(q32[0].ill));
            end
            check("in_ready64", 64'(b64.in_ready), 64'(q64.size() < 2));
            check("out_valid64", 64'(b64.out_valid), 64'(q64.size() > 0));
            if (q64.size() > 0) begin
                check("imm64", b64.Imm_out, q64[0].imm);
                check("target64", b64.target_out, q64[0].tgt);
                check("illegal64", 64'(b64.illegal_out), 64'(q64[0].ill));
            end
        end
    end

    // Called just after a negedge; returns at the negedge following acceptance.
    task automatic beat32(input logic [31:0] ins, input logic [31:0] p, input logic [2:0] sel);
        bit rdy;
        int n = 0;
        b32.in_valid    = 1'b1;
        b32.instruction = ins;
        b32.pc          = p;
`ifdef IMM_AUTODECODE_EN
        b32.ImmSel      = 3'b000;
`else
        b32.ImmSel      = sel;
`endif
        while (1) begin
            rdy = b32.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 20) begin
                n_chk++;
                $display("FAIL beat32_timeout: in_ready low for %0d cycles, expected 1", n);
                break;
            end
        end
        b32.in_valid = 1'b0;
    endtask

    task automatic beat64(input logic [31:0] ins, input logic [63:0] p, input logic [2:0] sel);
        bit rdy;
        int n = 0;
        b64.in_valid    = 1'b1;
        b64.instruction = ins;
        b64.pc          = p;
`ifdef IMM_AUTODECODE_EN
        b64.ImmSel      = 3'b000;
`else
        b64.ImmSel      = sel;
`endif
        while (1) begin
            rdy = b64.in_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 20) begin
                n_chk++;
                $display("FAIL beat64_timeout: in_ready low for %0d cycles, expected 1", n);
                break;
            end
        end
        b64.in_valid = 1'b0;
    endtask

    initial begin
        b32.in_valid = 0; b32.instruction = '0; b32.pc = '0; b32.ImmSel = '0; b32.out_ready = 1;
        b64.in_valid = 0; b64.instruction = '0; b64.pc = '0; b64.ImmSel = '0; b64.out_ready = 1;

        // Model pins
        check("model_B", model(32'hFE000EE3, 3'd2, 64'h200, 32).tgt, 64'h1FC);
        check("model_U64", model(32'h800000B7, 3'd3, 64'h0, 64).imm, 64'hFFFFFFFF80000000);

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(b32.in_ready), 64'd1);
        check("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check("rst_imm", 64'(b32.Imm_out), 64'd0);
        check("rst_target", 64'(b32.target_out), 64'd0);
        check("rst_illegal", 64'(b32.illegal_out), 64'd0);
        #2 reset = 1'b0;
        @(negedge clk);

        // Formats with out_ready high
        beat32(32'hFFF00093, 32'h100, 3'b000);
        check("I_imm", 64'(b32.Imm_out), 64'hFFFFFFFF);
        check("I_target", 64'(b32.target_out), 64'hFF);
        check("I_illegal", 64'(b32.illegal_out), 64'd0);
        beat32(32'h00112623, 32'h0, 3'b001);
        check("S_imm", 64'(b32.Imm_out), 64'hC);
        beat32(32'hFE000EE3, 32'h200, 3'b010);
        check("B_imm", 64'(b32.Imm_out), 64'hFFFFFFFC);
        check("B_target", 64'(b32.target_out), 64'h1FC);
        beat32(32'h123450B7, 32'h0, 3'b011);
        check("U_imm", 64'(b32.Imm_out), 64'h12345000);
        beat32(32'h001000EF, 32'h0, 3'b100);
        check("J_imm", 64'(b32.Imm_out), 64'h800);
        check("J_target", 64'(b32.target_out), 64'h800);
`ifdef IMM_AUTODECODE_EN
        beat32(32'h002081B3, 32'h300, 3'b000);
`else
        beat32(32'hFFF00093, 32'h300, 3'b101);
`endif
        check("bad_illegal", 64'(b32.illegal_out), 64'd1);
        check("bad_imm", 64'(b32.Imm_out), 64'd0);
        check("bad_target", 64'(b32.target_out), 64'h300);
        @(negedge clk);

        // Backpressure: two absorbed, third held, drain in order
        b32.out_ready = 1'b0;
        drained.delete();
        beat32(32'h00100093, 32'h0, 3'b000);
        beat32(32'h00200093, 32'h0, 3'b000);
        check("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
        fork
            beat32(32'h00300093, 32'h0, 3'b000);
            begin
                repeat (3) begin
                    check("bp_stall_imm", 64'(b32.Imm_out), 64'h1);
                    check("bp_stall_ready", 64'(b32.in_ready), 64'd0);
                    @(negedge clk);
                end
                b32.out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("bp_drain_count", 64'(drained.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check("bp_drain_order", (i < drained.size()) ? 64'(drained[i]) : 64'hDEAD, 64'(i + 1));
        check("bp_empty", 64'(b32.out_valid), 64'd0);

        // Flush in TWO with an input beat presented
        b32.out_ready = 1'b0;
        beat32(32'h00400093, 32'h0, 3'b000);
        beat32(32'h00500093, 32'h0, 3'b000);
        b32.in_valid = 1'b1; b32.instruction = 32'h00600093; b32.ImmSel = 3'b000;
        flush32 = 1'b1;
        @(posedge clk); @(negedge clk);
        flush32 = 1'b0; b32.in_valid = 1'b0;
        check("flush2_out_valid", 64'(b32.out_valid), 64'd0);
        check("flush2_in_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        check("flush2_dropped", 64'(b32.out_valid), 64'd0);

        // Flush in ONE has priority over a simultaneous accept
        beat32(32'h00700093, 32'h0, 3'b000);
        b32.in_valid = 1'b1; b32.instruction = 32'h00800093;
        flush32 = 1'b1;
        @(posedge clk); @(negedge clk);
        flush32 = 1'b0; b32.in_valid = 1'b0;
        check("flush1_dropped", 64'(b32.out_valid), 64'd0);

        // Asynchronous reset mid-stream
        beat32(32'h00500093, 32'h40, 3'b000);
        #3 reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(b32.out_valid), 64'd0);
        check("arst_imm", 64'(b32.Imm_out), 64'd0);
        check("arst_target", 64'(b32.target_out), 64'd0);
        check("arst_illegal", 64'(b32.illegal_out), 64'd0);
        check("arst_in_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        b32.out_ready = 1'b1;

        // RV64
        beat64(32'hFFF00093, 64'h0, 3'b000);
        check("I64_imm", b64.Imm_out, 64'hFFFFFFFFFFFFFFFF);
        beat64(32'h800000B7, 64'h0, 3'b011);
        check("U64_imm", b64.Imm_out, 64'hFFFFFFFF80000000);
        beat64(32'h01000093, 64'hFFFFFFFFFFFFFFF8, 3'b000);
        check("wrap64_imm", b64.Imm_out, 64'h10);
        check("wrap64_target", b64.target_out, 64'h8);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined immediate-generation stage for the RV32I datapath, successor to the single-cycle combinational immediate generator. It accepts an instruction, its PC and a format select under a valid/ready handshake. It produces the sign-extended immediate for all five RV32I immediate formats, plus the PC-relative target `pc + imm`. A 2-entry skid buffer lets it sit between fetch and execute without a combinational path from `out_ready` to `in_ready`. Width is parametrised for RV32 and RV64 use.

## Interface

**Parameters**
- `XLEN`, default 32: immediate, PC and target width. Legal values are 32 and 64.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `flush`, input, 1: synchronous discard of all buffered entries.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: stage can accept a beat.
- `instruction`, input, 32: raw instruction word.
- `pc`, input, XLEN: PC of the instruction.
- `ImmSel`, input, 3: format select. 000 = I, 001 = S, 010 = B, 011 = U, 100 = J, 101–111 = invalid.
- `out_valid`, output, 1: output beat valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `Imm_out`, output, XLEN: sign-extended immediate.
- `target_out`, output, XLEN: `pc + Imm_out`, modulo 2^XLEN.
- `illegal_out`, output, 1: the select (or opcode) was invalid.

## Operation

**Immediate formats.** Every format is sign-extended from `instruction[31]` to XLEN.
- I = `inst[31:20]`.
- S = `{inst[31:25], inst[11:7]}`.
- B = `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
- U = `{inst[31:12], 12'b0}`. For XLEN = 64, bits 63:32 are copies of `inst[31]`.
- J = `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
- Invalid select: `Imm_out = 0`, `target_out = pc`, `illegal_out = 1`.

**Computation point.** Decode and the adder are combinational on the input side. Results are captured into the buffer on acceptance.

**Handshakes.** A beat transfers on a clock edge where both valid and ready are high.
- Input side: `in_valid & in_ready`.
- Output side: `out_valid & out_ready`.

**State machine.** Entries are counted by a state register.
- `EMPTY`:
  - Accept moves to `ONE`.
- `ONE` (main register full):
  - Accept with no drain moves to `TWO`; the new entry goes to the skid register.
  - Accept with drain stays in `ONE`; main is reloaded.
  - Drain with no accept moves to `EMPTY`.
- `TWO` (main and skid full):
  - `in_ready = 0`.
  - Drain moves to `ONE`: skid shifts to main.
  - No input can be accepted in `TWO`, so accept with drain does not occur.

**Ready and valid generation.**
- `in_ready = (state != TWO)`; this is a function of registered state only.
- `out_valid = (state != EMPTY)`.

**Ordering.** Strict FIFO. Outputs are presented from the main register only.

**Stability.** While `out_valid & !out_ready`, all output data holds stable.

**Flush.**
- When `flush = 1` at a clock edge, the state becomes `EMPTY`.
- Any input beat presented on that edge is dropped.
- `flush` has priority over accept and drain.

**Reset.**
- Asserting `reset` mid-operation immediately forces `EMPTY`.
- All outputs go to 0 except `in_ready`, which becomes 1.

## Timing

- Latency is 1 cycle. A beat accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 beat per cycle when `out_ready` is held high.
- When `out_ready` is low, two beats are absorbed. `in_ready` falls in the cycle after the second acceptance.
- Reset values:
  - `out_valid = 0`
  - `Imm_out = 0`
  - `target_out = 0`
  - `illegal_out = 0`
  - `in_ready = 1`
  - state = `EMPTY`
- The data registers are not required to be cleared on drain; only valid tracking matters.

## Configuration

Macro: `IMM_AUTODECODE_EN`.

**Defined.** The `ImmSel` input is ignored. The format is derived from `instruction[6:0]`:
- 0000011, 0010011, 1100111, 1110011 → I.
- 0100011 → S.
- 1100011 → B.
- 0110111, 0010111 → U.
- 1101111 → J.
- Any other opcode, including R-type 0110011 → invalid: `illegal_out = 1`, `Imm_out = 0`.

**Undefined.** The format comes from `ImmSel` exactly as listed under Interface.

## Test plan

1. **I-type and S-type, XLEN = 32.** With `out_ready` high, each output appears one cycle after acceptance.
   - `instruction = 0xFFF00093`, `ImmSel = 000`, `pc = 0x100` → `Imm_out = 0xFFFFFFFF`, `target_out = 0x000000FF`.
   - S-type sanity case: `0x00112623` (sw x1,12(x2)) with `ImmSel = 001` → `Imm_out = 0x0000000C`.
2. **B, U and J formats.**
   - `0xFE000EE3` with `ImmSel = 010`, `pc = 0x200` → `Imm_out = 0xFFFFFFFC`, `target_out = 0x000001FC`.
   - `0x123450B7` with `ImmSel = 011` → `Imm_out = 0x12345000`.
   - `0x001000EF` with `ImmSel = 100`, `pc = 0` → `Imm_out = 0x00000800`, `target_out = 0x800`.
3. **Backpressure.** Hold `out_ready = 0` and offer 3 beats back-to-back.
   - The first 2 are accepted; `in_ready` is low from the cycle after the second.
   - The third beat is held until space frees.
   - Then raise `out_ready`: the outputs drain in order 1, 2, 3 with no loss or duplication, and outputs stay stable while stalled.
4. **Invalid select, flush and reset.**
   - `ImmSel = 101` → `illegal_out = 1`, `Imm_out = 0`, `target_out = pc`.
   - In state `TWO`, assert `flush` together with `in_valid` → next cycle `out_valid = 0`, `in_ready = 1`, and the input beat is dropped.
   - Assert `reset` asynchronously mid-stream → outputs are immediately 0 and `in_ready = 1`.
5. **XLEN = 64.**
   - `0xFFF00093`, I-type → `Imm_out = 0xFFFFFFFFFFFFFFFF`.
   - `0x800000B7`, U-type → `Imm_out = 0xFFFFFFFF80000000`.
   - `pc = 0xFFFFFFFFFFFFFFF8` with imm 0x10 wraps to `target_out = 0x8`.
6. **With `IMM_AUTODECODE_EN` defined**, hold `ImmSel = 000` throughout.
   - `0xFE000EE3` still decodes as B: `Imm_out = 0xFFFFFFFC`.
   - `0x002081B3` (add) → `illegal_out = 1`, `Imm_out = 0`.
